// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared definitions for the convolution filter scheduler:
//                scheduler state encoding, default geometry and the helper
//                functions that derive counter widths and per-filter output
//                counts from the feature-map / kernel geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

   // Default layer geometry.
   localparam int DEF_COLUMN_SIZE = 28;
   localparam int DEF_KERNEL_SIZE = 3;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_NUM_FILTERS = 8;

   // Scheduler states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_NEXT   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Side of the valid-convolution output map.
   function automatic int out_side(input int column_size, input int kernel_size);
      return column_size - kernel_size + 1;
   endfunction

   // OUT_PER_FILTER: number of engine results expected for one filter.
   function automatic int out_per_filter(input int column_size, input int kernel_size);
      return out_side(column_size, kernel_size) * out_side(column_size, kernel_size);
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_filter_scheduler_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : Row/column raster counter over a SIZE x SIZE map. Advances
//                one position per inc, column first, wrapping the column at
//                SIZE-1 with a row increment and wrapping the row at SIZE-1.
//  Ports       : clock, sreset_n (async active-low), clear (sync, wins over
//                inc), inc, row, col, last (row and col both at SIZE-1)
//  Revision    : 1.0  initial release
// ============================================================================
module raster_counter
   import conv_pkg::*;
#(
   parameter int SIZE = 28
) (
   input  logic                       clock,
   input  logic                       sreset_n,
   input  logic                       clear,
   input  logic                       inc,
   output logic [cnt_width(SIZE)-1:0] row,
   output logic [cnt_width(SIZE)-1:0] col,
   output logic                       last
);

   localparam int                 C_W   = cnt_width(SIZE);
   localparam logic [C_W-1:0]     C_MAX = C_W'(SIZE - 1);

   always_ff @(posedge clock or negedge sreset_n) begin
      if (!sreset_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col == C_MAX) begin
            col <= '0;
            row <= (row == C_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (row == C_MAX) && (col == C_MAX);

endmodule
`default_nettype wire

// File: rtl/conv_filter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : conv_filter_scheduler
//  Description : Sequences NUM_FILTERS filters through one shared convolution
//                engine. Per filter: fetch weights (LOAD), stream one full
//                COLUMN_SIZE^2 feature map (STREAM), wait for the remaining
//                engine results (DRAIN), then move to the next filter (NEXT).
//                Engine results are tagged with filter index and output
//                row/column; unexpected results raise a sticky err.
//  Ports       : clock, sreset_n          - clock, async active-low reset
//                start, abort, busy, done, err - layer control / status
//                w_req, w_addr, w_ack      - weight fetch handshake
//                pix_valid, pix_ready      - pixel stream handshake
//                eng_valid, eng_rst_n,
//                eng_convol_valid/out      - engine interface
//                out_valid, out_data, out_filter, out_row, out_col - results
//  Revision    : 1.0  initial release
// ============================================================================
module conv_filter_scheduler
   import conv_pkg::*;
#(
   parameter int COLUMN_SIZE = DEF_COLUMN_SIZE,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_FILTERS = DEF_NUM_FILTERS
) (
   input  logic                              clock,
   input  logic                              sreset_n,
   input  logic                              start,
   input  logic                              abort,
   output logic                              busy,
   output logic                              done,
   output logic                              err,
   output logic                              w_req,
   output logic [cnt_width(NUM_FILTERS)-1:0] w_addr,
   input  logic                              w_ack,
   input  logic                              pix_valid,
   output logic                              pix_ready,
   output logic                              eng_valid,
   output logic                              eng_rst_n,
   input  logic                              eng_convol_valid,
   input  logic [DATA_WIDTH-1:0]             eng_convol_out,
   output logic                              out_valid,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic [cnt_width(NUM_FILTERS)-1:0] out_filter,
   output logic [cnt_width(COLUMN_SIZE)-1:0] out_row,
   output logic [cnt_width(COLUMN_SIZE)-1:0] out_col
);

   localparam int             C_FW          = cnt_width(NUM_FILTERS);
   localparam int             C_CW          = cnt_width(COLUMN_SIZE);
   localparam int             C_OUT_SIDE    = out_side(COLUMN_SIZE, KERNEL_SIZE);
   localparam int             C_OW          = cnt_width(C_OUT_SIDE);
   localparam logic [C_FW-1:0] C_LAST_FILTER = C_FW'(NUM_FILTERS - 1);
   localparam logic [C_CW-1:0] C_FIRST_ROW   = C_CW'(KERNEL_SIZE - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [C_FW-1:0]   r_filter;
   logic [C_FW-1:0]   w_filter_nxt;
   logic              r_was_load;
   logic              r_outs_done;
   logic              r_err;
   logic              w_eng_clr;
   logic              w_accept;
   logic              w_cnt_clear;
   logic              w_pix_last;
   logic              w_out_last;
   logic              w_in_window;
   logic              w_bad_conv;
   logic [C_CW-1:0]   w_pix_row;
   logic [C_CW-1:0]   w_pix_col_unused;
   logic [C_OW-1:0]   w_out_row;
   logic [C_OW-1:0]   w_out_col;

   // ------------------------------------------------------------------------
   // State register and per-filter bookkeeping
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge sreset_n) begin
      if (!sreset_n) begin
         r_state     <= ST_IDLE;
         r_filter    <= '0;
         r_was_load  <= 1'b0;
         r_outs_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_filter   <= w_filter_nxt;
         r_was_load <= (r_state == ST_LOAD);
         // Marks that OUT_PER_FILTER results have been seen for this filter;
         // anything further from the engine is an error.
         if (w_cnt_clear)
            r_outs_done <= 1'b0;
         else if (out_valid && w_out_last)
            r_outs_done <= 1'b1;
         // A fresh error wins over the clear from a simultaneous start.
         if (w_bad_conv)
            r_err <= 1'b1;
         else if (start && (r_state == ST_IDLE))
            r_err <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_filter_nxt = r_filter;
      busy         = 1'b0;
      done         = 1'b0;
      w_req        = 1'b0;
      w_eng_clr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt  = ST_LOAD;
               w_filter_nxt = '0;
            end
         end
         ST_LOAD: begin
            busy      = 1'b1;
            w_req     = 1'b1;
            // Engine is cleared once, on entry to LOAD.
            w_eng_clr = !r_was_load;
            if (w_ack)
               w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            busy = 1'b1;
            if (w_accept && w_pix_last)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            // Registered flag: a final result coincident with the last pixel
            // still spends one cycle here.
            if (r_outs_done)
               w_state_nxt = ST_NEXT;
         end
         ST_NEXT: begin
            busy = 1'b1;
            if (r_filter != C_LAST_FILTER) begin
               w_filter_nxt = r_filter + 1'b1;
               w_state_nxt  = ST_LOAD;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Abort overrides every other transition.
      if (abort && (r_state != ST_IDLE)) begin
         w_state_nxt  = ST_IDLE;
         w_filter_nxt = '0;
         w_eng_clr    = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath strobes
   // ------------------------------------------------------------------------
   assign pix_ready   = (r_state == ST_STREAM);
   assign w_accept    = pix_valid && pix_ready;
   // Rows above KERNEL_SIZE-1 cannot complete a window; columns are gated by
   // the engine itself.
   assign eng_valid   = w_accept && (w_pix_row >= C_FIRST_ROW);
   assign w_cnt_clear = abort || !((r_state == ST_STREAM) || (r_state == ST_DRAIN));
   assign w_in_window = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
   assign out_valid   = eng_convol_valid && w_in_window && !r_outs_done;
   assign w_bad_conv  = eng_convol_valid && !out_valid;
   assign eng_rst_n   = sreset_n && !w_eng_clr;

   assign err        = r_err;
   assign w_addr     = r_filter;
   assign out_filter = r_filter;
   assign out_data   = eng_convol_out;
   assign out_row    = C_CW'(w_out_row);
   assign out_col    = C_CW'(w_out_col);

   raster_counter #(
      .SIZE     (COLUMN_SIZE)
   ) u_pix_cnt (
      .clock    (clock),
      .sreset_n (sreset_n),
      .clear    (w_cnt_clear),
      .inc      (w_accept),
      .row      (w_pix_row),
      .col      (w_pix_col_unused),
      .last     (w_pix_last)
   );

   raster_counter #(
      .SIZE     (C_OUT_SIDE)
   ) u_out_cnt (
      .clock    (clock),
      .sreset_n (sreset_n),
      .clear    (w_cnt_clear),
      .inc      (out_valid),
      .row      (w_out_row),
      .col      (w_out_col),
      .last     (w_out_last)
   );

endmodule
`default_nettype wire

// File: tb/tb_conv_filter_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_conv_filter_scheduler
//  Description : Directed self-checking bench for conv_filter_scheduler with
//                a 6x6 map, 3x3 kernel, two filters and a 4-cycle engine
//                model that performs its own column gating.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_filter_scheduler;

   localparam int CS = 6;
   localparam int KS = 3;
   localparam int DW = 16;
   localparam int NF = 2;
   localparam int OS = CS - KS + 1;
   localparam int OPF = OS * OS;

   logic          clock = 1'b0;
   logic          sreset_n, start, abort, w_ack, pix_valid, inj;
   logic          busy, done, err, w_req, pix_ready, eng_valid, eng_rst_n;
   logic          eng_convol_valid, out_valid;
   logic [DW-1:0] eng_convol_out, out_data;
   logic [0:0]    w_addr, out_filter;
   logic [2:0]    out_row, out_col;

   always #5 clock = ~clock;

   conv_filter_scheduler #(
      .COLUMN_SIZE      (CS),
      .KERNEL_SIZE      (KS),
      .DATA_WIDTH       (DW),
      .NUM_FILTERS      (NF)
   ) dut (
      .clock            (clock),
      .sreset_n         (sreset_n),
      .start            (start),
      .abort            (abort),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .w_req            (w_req),
      .w_addr           (w_addr),
      .w_ack            (w_ack),
      .pix_valid        (pix_valid),
      .pix_ready        (pix_ready),
      .eng_valid        (eng_valid),
      .eng_rst_n        (eng_rst_n),
      .eng_convol_valid (eng_convol_valid),
      .eng_convol_out   (eng_convol_out),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_filter       (out_filter),
      .out_row          (out_row),
      .out_col          (out_col)
   );

   // Engine model: column gating plus 4-cycle result pipeline.
   logic [3:0]    pv;
   logic [DW-1:0] pd [4];
   int            e_col, e_n;

   always @(posedge clock or negedge sreset_n) begin
      if (!sreset_n || !eng_rst_n) begin
         pv    <= '0;
         e_col <= 0;
         e_n   <= 0;
      end else begin
         pv    <= {pv[2:0], eng_valid && (e_col >= KS - 1)};
         pd[0] <= 16'(32'hA000 + e_n * 3);
         pd[1] <= pd[0];
         pd[2] <= pd[1];
         pd[3] <= pd[2];
         if (eng_valid) begin
            e_col <= (e_col == CS - 1) ? 0 : e_col + 1;
            if (e_col >= KS - 1) e_n <= e_n + 1;
         end
      end
   end
   assign eng_convol_valid = pv[3] | inj;
   assign eng_convol_out   = pd[3];

   // Monitor
   logic mon_clr;
   int   n_pix_f [2];
   int   n_eng_f [2];
   int   n_out, n_done, n_bad_ready, cur_f;
   int   cap_d [64];
   int   cap_f [64];
   int   cap_r [64];
   int   cap_c [64];

   always @(negedge clock) begin
      if (mon_clr) begin
         n_pix_f[0] = 0; n_pix_f[1] = 0; n_eng_f[0] = 0; n_eng_f[1] = 0;
         n_out = 0; n_done = 0; n_bad_ready = 0; cur_f = 0;
      end else begin
         if (w_req) cur_f = int'(w_addr);
         if (pix_valid && pix_ready) n_pix_f[cur_f] = n_pix_f[cur_f] + 1;
         if (eng_valid && (e_col >= KS - 1)) n_eng_f[cur_f] = n_eng_f[cur_f] + 1;
         if (out_valid && n_out < 64) begin
            cap_d[n_out] = int'(out_data);
            cap_f[n_out] = int'(out_filter);
            cap_r[n_out] = int'(out_row);
            cap_c[n_out] = int'(out_col);
            n_out = n_out + 1;
         end
         if (done) n_done = n_done + 1;
         if (pix_ready && (!busy || w_req)) n_bad_ready = n_bad_ready + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_w_req"}, w_req, 0);
      check({tag, "_pix_ready"}, pix_ready, 0);
      check({tag, "_eng_valid"}, eng_valid, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_eng_rst_n"}, eng_rst_n, 0);
   endtask

   // result: 1 = done seen, 2 = deliberately cut short, 0 = timeout
   task automatic run_layer(input bit toggle, input int abort_at, input bit poke,
                            input bit do_inj, input bit rst_drain, output int result);
      int  load_cnt = 0;
      bit  poked = 0;
      bit  injected = 0;
      result = 0;
      @(posedge clock); #1;
      mon_clr = 1'b1;
      @(posedge clock); #1;
      mon_clr = 1'b0;
      start   = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) begin
            @(posedge clock); #1;
         end
         start = 1'b0; w_ack = 1'b0; abort = 1'b0; inj = 1'b0;
         pix_valid = toggle ? !pix_valid : 1'b1;
         if (cyc == 0) begin
            check("busy_after_start", busy, 1);
            check("err_after_start", err, 0);
         end
         if (w_req) begin
            load_cnt++;
            if (load_cnt == 3) w_ack = 1'b1;
         end else begin
            load_cnt = 0;
         end
         if (done) begin
            check("busy_in_done", busy, 0);
            result = 1;
            return;
         end
         if (abort_at >= 0 && n_pix_f[1] >= abort_at) begin
            abort = 1'b1;
            #1 check("eng_rst_on_abort", eng_rst_n, 0);
            @(posedge clock); #1;
            abort = 1'b0; pix_valid = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_pix_ready", pix_ready, 0);
            check("abort_eng_rst_released", eng_rst_n, 1);
            repeat (6) @(posedge clock);
            #1;
            check("abort_no_done", n_done, 0);
            check("abort_still_idle", busy, 0);
            result = 2;
            return;
         end
         if (poke && !poked && n_pix_f[0] == 10) begin
            start = 1'b1; w_ack = 1'b1; poked = 1;
         end
         if (do_inj && !injected && n_out == OPF) begin
            inj = 1'b1; injected = 1;
            #1 check("extra_conv_no_out", out_valid, 0);
            @(posedge clock); #1;
            inj = 1'b0;
            check("extra_conv_err", err, 1);
         end
         if (rst_drain && n_pix_f[1] == CS * CS && busy && !w_req && !pix_ready) begin
            sreset_n = 1'b0;
            #1 check_reset_outputs("rst_drain");
            repeat (2) @(posedge clock);
            #1 sreset_n = 1'b1;
            repeat (4) @(posedge clock);
            #1;
            check("rst_drain_no_done", n_done, 0);
            check("rst_drain_idle", busy, 0);
            result = 2;
            return;
         end
      end
      check("layer_timeout", 0, 1);
   endtask

   task automatic verify_layer(input string name);
      int idx;
      repeat (3) @(posedge clock);
      #1;
      check({name, "_pix_f0"}, n_pix_f[0], CS * CS);
      check({name, "_pix_f1"}, n_pix_f[1], CS * CS);
      check({name, "_eng_f0"}, n_eng_f[0], OPF);
      check({name, "_eng_f1"}, n_eng_f[1], OPF);
      check({name, "_outs"}, n_out, NF * OPF);
      check({name, "_done_pulses"}, n_done, 1);
      check({name, "_idle_busy"}, busy, 0);
      for (int k = 0; k < NF * OPF; k++) begin
         idx = k % OPF;
         check($sformatf("%s_filter[%0d]", name, k), cap_f[k], k / OPF);
         check($sformatf("%s_row[%0d]", name, k), cap_r[k], idx / OS);
         check($sformatf("%s_col[%0d]", name, k), cap_c[k], idx % OS);
         check($sformatf("%s_data[%0d]", name, k), cap_d[k], 32'hA000 + idx * 3);
      end
   endtask

   initial begin
      int res;
      sreset_n = 1'b0; start = 1'b0; abort = 1'b0; w_ack = 1'b0;
      pix_valid = 1'b0; inj = 1'b0; mon_clr = 1'b1;
      repeat (3) @(posedge clock);
      #1 check_reset_outputs("reset");
      sreset_n = 1'b1;
      #1 check("eng_rst_idle", eng_rst_n, 1);

      // Continuous pixels
      run_layer(1'b0, -1, 1'b0, 1'b0, 1'b0, res);
      check("cont_result", res, 1);
      verify_layer("cont");
      check("cont_err", err, 0);

      // Toggling pixels
      run_layer(1'b1, -1, 1'b0, 1'b0, 1'b0, res);
      check("tog_result", res, 1);
      verify_layer("tog");
      check("tog_ready_outside_stream", n_bad_ready, 0);

      // Abort after 20 pixels of filter 1, then a clean layer
      run_layer(1'b0, 20, 1'b0, 1'b0, 1'b0, res);
      check("abort_result", res, 2);
      run_layer(1'b0, -1, 1'b0, 1'b0, 1'b0, res);
      check("post_abort_result", res, 1);
      verify_layer("post_abort");

      // Extra engine result in filter 0; err is sticky until the next start
      run_layer(1'b0, -1, 1'b0, 1'b1, 1'b0, res);
      check("inj_result", res, 1);
      verify_layer("inj");
      check("inj_err_sticky", err, 1);

      // start / w_ack pulsed during STREAM are ignored
      run_layer(1'b0, -1, 1'b1, 1'b0, 1'b0, res);
      check("poke_result", res, 1);
      verify_layer("poke");
      check("poke_err", err, 0);

      // Reset during DRAIN of filter 1, then a clean layer
      run_layer(1'b0, -1, 1'b0, 1'b0, 1'b1, res);
      check("rst_result", res, 2);
      run_layer(1'b0, -1, 1'b0, 1'b0, 1'b0, res);
      check("post_rst_result", res, 1);
      verify_layer("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
